// File: rtl/pulse_meter_pkg.sv
// Shared types and constants for the pulse period meter: counter width,
// FSM state encoding and a saturating increment helper.
package pulse_meter_pkg;

    localparam int CNT_W = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        MEASURING = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pulse_edge_sync.sv
// Two-flop synchronizer, optional glitch filter (PULSE_PERIOD_GLITCH_FILTER_EN)
// and registered rising-edge detector for the asynchronous pulse input.
module pulse_edge_sync #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic r,
    input  logic d,
    output logic rise
);

    if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
        $error("FILTER_LEN must be in 1..15");
    end

    logic       s1_reg;
    logic       s2_reg;
    logic [1:0] prime_reg;
    logic       seen_low_reg;
    logic       prev_reg;
    logic       rise_reg;
    logic       lvl;

    // A rise is only believed once the real input has been seen low after
    // reset; otherwise releasing reset mid-pulse would look like an edge.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            s1_reg       <= 1'b0;
            s2_reg       <= 1'b0;
            prime_reg    <= 2'd0;
            seen_low_reg <= 1'b0;
            prev_reg     <= 1'b0;
            rise_reg     <= 1'b0;
        end else begin
            s1_reg <= d;
            s2_reg <= s1_reg;
            if (prime_reg != 2'd2)
                prime_reg <= prime_reg + 2'd1;
            if (prime_reg == 2'd2 && !s2_reg)
                seen_low_reg <= 1'b1;
            prev_reg <= lvl;
            rise_reg <= lvl & ~prev_reg & seen_low_reg;
        end
    end

`ifdef PULSE_PERIOD_GLITCH_FILTER_EN
    logic       filt_reg;
    logic [3:0] run_reg;

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            filt_reg <= 1'b0;
            run_reg  <= 4'd0;
        end else if (s2_reg == filt_reg) begin
            run_reg <= 4'd0;
        end else if (run_reg == 4'(FILTER_LEN - 1)) begin
            filt_reg <= s2_reg;
            run_reg  <= 4'd0;
        end else begin
            run_reg <= run_reg + 4'd1;
        end
    end

    assign lvl = filt_reg;
`else
    assign lvl = s2_reg;
`endif

    assign rise = rise_reg;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures rising-edge-to-rising-edge period of an asynchronous pulse in clk
// cycles, with timeout detection. Optional glitch filter: PULSE_PERIOD_GLITCH_FILTER_EN.
module pulse_period_meter
    import pulse_meter_pkg::*;
#(
    parameter logic [CNT_W-1:0] TIMEOUT    = 32'd100_000_000,
    parameter int               FILTER_LEN = 4
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             timeout,
    output logic [CNT_W-1:0] edge_count
);

    logic             rise;
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] edge_count_reg;
    logic             period_valid_reg;
    logic             timeout_reg;

    pulse_edge_sync #(
        .FILTER_LEN(FILTER_LEN)
    ) u_edge (
        .clk (clk),
        .r   (r),
        .d   (pulse_in),
        .rise(rise)
    );

    // Strobes default low every cycle; en=0 wins over any edge or timeout.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            period_reg       <= '0;
            edge_count_reg   <= '0;
            period_valid_reg <= 1'b0;
            timeout_reg      <= 1'b0;
        end else begin
            period_valid_reg <= 1'b0;
            timeout_reg      <= 1'b0;
            if (!en) begin
                state_reg <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg      <= ARMED;
                        cnt_reg        <= '0;
                        edge_count_reg <= '0;
                    end
                    ARMED: begin
                        if (rise) begin
                            cnt_reg        <= 32'd1;
                            edge_count_reg <= edge_count_reg + 32'd1;
                            state_reg      <= MEASURING;
                        end
                    end
                    MEASURING: begin
                        if (rise) begin
                            period_reg       <= cnt_reg;
                            period_valid_reg <= 1'b1;
                            cnt_reg          <= 32'd1;
                            edge_count_reg   <= edge_count_reg + 32'd1;
                        end else if (cnt_reg == TIMEOUT) begin
                            timeout_reg <= 1'b1;
                            state_reg   <= ARMED;
                        end else begin
                            cnt_reg <= sat_inc(cnt_reg);
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign period       = period_reg;
    assign period_valid = period_valid_reg;
    assign timeout      = timeout_reg;
    assign edge_count   = edge_count_reg;

endmodule

// File: doc/pulse_period_meter.md
PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32'd100_000_000, the clk-cycle count after which a missing edge is declared a timeout.
REQ-002 SHALL have parameter FILTER_LEN, default 4, the number of stable cycles the glitch filter requires (range 1..15).
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 r  input  1  reset; asynchronous and active-high.
REQ-005 en  input  1  measurement enable; synchronous.
REQ-006 pulse_in  input  1  external step pulse; asynchronous to clk.
REQ-007 period  output  32  last measured rising-edge-to-rising-edge interval, in clk cycles.
REQ-008 period_valid  output  1  one-cycle strobe when period updates.
REQ-009 timeout  output  1  one-cycle strobe when no edge arrives within TIMEOUT cycles.
REQ-010 edge_count  output  32  number of accepted rising edges since reset or en rise; wraps modulo 2^32.

Function
REQ-011 pulse_in SHALL pass a 2-flop synchronizer and then a registered rising-edge detector, so an edge strobe occurs 3 clk cycles after the pulse_in rise.
REQ-012 The FSM SHALL have states IDLE, ARMED and MEASURING.
REQ-013 IDLE: SHALL move to ARMED when en=1; SHALL clear cnt and edge_count on that transition.
REQ-014 ARMED: on edge, SHALL set cnt=1, increment edge_count and move to MEASURING; SHALL NOT assert period_valid.
REQ-015 MEASURING, no edge: SHALL increment cnt by 1 per cycle, saturating at 32'hFFFF_FFFF.
REQ-016 MEASURING, edge: SHALL load period<=cnt, pulse period_valid the following cycle, reset cnt=1 and increment edge_count; edges N cycles apart yield period=N.
REQ-017 MEASURING, cnt==TIMEOUT with no edge: SHALL pulse timeout for one cycle, hold period, and move to ARMED.
REQ-018 An edge in the same cycle as cnt==TIMEOUT SHALL count as a normal measurement (period=TIMEOUT) with no timeout strobe.
REQ-019 en=0 in any state SHALL force IDLE on the next edge of clk, overriding a coincident edge or timeout; period and edge_count SHALL hold; strobes SHALL be 0.
REQ-020 period_valid and timeout SHALL never be asserted in the same cycle.

Reset
REQ-021 With r=1: state=IDLE, cnt=0, period=0, edge_count=0, period_valid=0, timeout=0, synchronizer and filter flops=0, all immediately and independent of clk.
REQ-022 Reset deassertion mid-pulse SHALL NOT produce an edge unless a full low-to-high transition is seen after reset.

Configuration
REQ-023 Macro PULSE_PERIOD_GLITCH_FILTER_EN defined: the synchronized input SHALL change its filtered level only after FILTER_LEN consecutive equal samples, adding FILTER_LEN cycles of edge latency.
REQ-024 Macro undefined: no filter logic; the edge detector SHALL use the synchronizer output directly, and FILTER_LEN SHALL be ignored.

Structure
REQ-025 Package pulse_meter_pkg SHALL hold CNT_W=32, the FSM state enum (IDLE/ARMED/MEASURING) and CNT_MAX.
REQ-026 Synchronizer, optional filter and edge detector SHALL live in sub-module pulse_edge_sync (inputs: clk, r, d; output: rise).

Verification
REQ-027 Bench: en=1; pulse_in rises at t0, t0+1000, and t0+2000 cycles -> period=1000 with period_valid at 2 strobes; edge_count=3.
REQ-028 Bench: TIMEOUT=500; single edge, then silence -> timeout strobe 500 cycles after the edge; state ARMED; next two edges 200 apart -> period=200.
REQ-029 Bench: edges exactly 500 apart with TIMEOUT=500 -> period=500, no timeout strobe.
REQ-030 Bench: en dropped at the edge cycle mid-measurement -> no period_valid; period holds the previous value; re-enabling clears edge_count to 0.
REQ-031 Bench: r asserted asynchronously while MEASURING at cnt=37 -> all outputs 0 before the next clk edge.
REQ-032 Bench: macro defined, FILTER_LEN=4, 2-cycle high glitch -> no edge; 6-cycle high pulse -> one edge, 4 cycles later than in the build without the macro.
